// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of an asynchronous PWM input.
// pwm_in is brought into the clk domain with a 2-flop synchronizer.
// An optional glitch filter is enabled by defining PWM_GLITCH_FILTER_EN. With the
// filter, the level changes only after FILT_LEN consecutive equal samples.
// A four-state FSM counts the high time and the period between filtered rising edges.
// Counters saturate instead of wrapping.
// A no-edge watchdog raises stuck_high or stuck_low after TIMEOUT cycles.
module pwm_duty_meter #(
    parameter int CNT_W    = 17,
    parameter int TIMEOUT  = 120000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             enable,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int               RUN_W   = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    // Saturating increment: a counter parks at its maximum rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [1:0]       sync_r;
    logic             lvl_s;
    logic             lvl_d_r;
    logic             rise_s;
    logic             fall_s;
    logic             edge_s;
    logic             timeout_s;
    logic [RUN_W-1:0] run_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] pcnt_r;
    logic [CNT_W-1:0] high_cnt_r;
    logic [CNT_W-1:0] period_cnt_r;
    logic             meas_valid_r;
    logic             stuck_high_r;
    logic             stuck_low_r;
    logic             overflow_r;
    state_t           state_r;

    // Two-flop synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pwm_in};
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int               FILT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

    logic [FILT_W-1:0] filt_cnt_r;
    logic              filt_r;

    // Glitch filter: the level changes only after FILT_LEN samples that all differ from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_r <= {FILT_W{1'b0}};
            filt_r     <= 1'b0;
        end else if (sync_r[1] == filt_r) begin
            filt_cnt_r <= {FILT_W{1'b0}};
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_cnt_r <= {FILT_W{1'b0}};
            filt_r     <= sync_r[1];
        end else begin
            filt_cnt_r <= filt_cnt_r + FILT_W'(1);
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = sync_r[1];
`endif

    // Registered copy of the filtered level, used for one-cycle edge flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d_r <= 1'b0;
        end else begin
            lvl_d_r <= lvl_s;
        end
    end

    assign rise_s    = lvl_s & ~lvl_d_r;
    assign fall_s    = ~lvl_s & lvl_d_r;
    assign edge_s    = rise_s | fall_s;
    assign timeout_s = enable && (state_r != IDLE) && !edge_s && (run_r == RUN_LAST);

    // No-edge run counter. It parks at TIMEOUT, so each quiet stretch reports only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= {RUN_W{1'b0}};
        end else if (!enable || (state_r == IDLE) || edge_s) begin
            run_r <= {RUN_W{1'b0}};
        end else if (run_r != RUN_TOP) begin
            run_r <= run_r + RUN_W'(1);
        end else begin
            run_r <= run_r;
        end
    end

    // Measurement FSM: owns the running counters, the latched results and the status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            hcnt_r       <= {CNT_W{1'b0}};
            pcnt_r       <= {CNT_W{1'b0}};
            high_cnt_r   <= {CNT_W{1'b0}};
            period_cnt_r <= {CNT_W{1'b0}};
            meas_valid_r <= 1'b0;
            stuck_high_r <= 1'b0;
            stuck_low_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            meas_valid_r <= 1'b0;
            if (edge_s) begin
                stuck_high_r <= 1'b0;
                stuck_low_r  <= 1'b0;
            end
            if (!enable) begin
                state_r <= IDLE;
            end else if (timeout_s) begin
                state_r <= WAIT_RISE;
                if (lvl_s) begin
                    stuck_high_r <= 1'b1;
                end else begin
                    stuck_low_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (rise_s) begin
                            hcnt_r  <= CNT_ONE;
                            pcnt_r  <= CNT_ONE;
                            state_r <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        pcnt_r <= sat_inc(pcnt_r);
                        if (fall_s) begin
                            state_r <= MEAS_LOW;
                        end else begin
                            hcnt_r <= sat_inc(hcnt_r);
                        end
                    end
                    MEAS_LOW: begin
                        if (rise_s) begin
                            high_cnt_r   <= hcnt_r;
                            period_cnt_r <= pcnt_r;
                            overflow_r   <= (pcnt_r == CNT_MAX);
                            meas_valid_r <= 1'b1;
                            hcnt_r       <= CNT_ONE;
                            pcnt_r       <= CNT_ONE;
                            state_r      <= MEAS_HIGH;
                        end else begin
                            pcnt_r <= sat_inc(pcnt_r);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign high_cnt   = high_cnt_r;
    assign period_cnt = period_cnt_r;
    assign meas_valid = meas_valid_r;
    assign stuck_high = stuck_high_r;
    assign stuck_low  = stuck_low_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter. It drives PWM waveforms whose high and low times are known.
// Expected measurements and pulse times come from those durations.
module tb_pwm_duty_meter;

    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 1000;
    localparam int FILT_LEN = 4;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif
    localparam int SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic             enable;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic             overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int q_hc[$];
    int q_pc[$];
    int q_ov[$];
    int q_cyc[$];
    int rise_q[$];
    int exp_hc = 0;
    int exp_pc = 0;
    int exp_ov = 0;

    pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
        .stuck_high(stuck_high), .stuck_low(stuck_low), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every measurement pulse with its value and its cycle.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            q_hc.push_back(int'(high_cnt));
            q_pc.push_back(int'(period_cnt));
            q_ov.push_back(int'(overflow));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic drive(input logic lvl, input int n);
        if (lvl && !pwm_in) rise_q.push_back(cyc);
        pwm_in = lvl;
        repeat (n) step();
    endtask

    task automatic clear_log();
        q_hc.delete(); q_pc.delete(); q_ov.delete(); q_cyc.delete(); rise_q.delete();
    endtask

    task automatic restart();
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (LAT + 6) step();
        clear_log();
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks += 6;
        if (high_cnt !== 0)   begin failures++; $display("FAIL reset_high_cnt got %0d want 0", high_cnt); end
        if (period_cnt !== 0) begin failures++; $display("FAIL reset_period_cnt got %0d want 0", period_cnt); end
        if (meas_valid !== 0) begin failures++; $display("FAIL reset_meas_valid got %0b want 0", meas_valid); end
        if (stuck_high !== 0) begin failures++; $display("FAIL reset_stuck_high got %0b want 0", stuck_high); end
        if (stuck_low !== 0)  begin failures++; $display("FAIL reset_stuck_low got %0b want 0", stuck_low); end
        if (overflow !== 0)   begin failures++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic_30_70();
        restart();
        repeat (4) begin drive(1'b1, 30); drive(1'b0, 70); end
        drive(1'b1, 1);
        repeat (LAT + 2) step();
        checks++;
        if (q_hc.size() !== 4) begin failures++; $display("FAIL basic_count got %0d want 4", q_hc.size()); end
        for (int i = 0; i < q_hc.size() && i < 4; i++) begin
            checks += 4;
            if (q_hc[i] !== 30)  begin failures++; $display("FAIL basic_hc[%0d] got %0d want 30", i, q_hc[i]); end
            if (q_pc[i] !== 100) begin failures++; $display("FAIL basic_pc[%0d] got %0d want 100", i, q_pc[i]); end
            if (q_ov[i] !== 0)   begin failures++; $display("FAIL basic_ov[%0d] got %0d want 0", i, q_ov[i]); end
            if (q_cyc[i] !== rise_q[i+1] + LAT) begin
                failures++; $display("FAIL basic_time[%0d] got %0d want %0d", i, q_cyc[i], rise_q[i+1] + LAT);
            end
        end
        exp_hc = 30; exp_pc = 100; exp_ov = 0;
    endtask

    task automatic test_random_periods();
        int hs[8];
        int ls[8];
        int p;
        restart();
        for (int i = 0; i < 8; i++) begin
            hs[i] = int'($urandom_range(5, 60));
            ls[i] = int'($urandom_range(5, 60));
            drive(1'b1, hs[i]);
            drive(1'b0, ls[i]);
        end
        drive(1'b1, 1);
        repeat (LAT + 2) step();
        checks++;
        if (q_hc.size() !== 8) begin failures++; $display("FAIL rand_count got %0d want 8", q_hc.size()); end
        for (int i = 0; i < q_hc.size() && i < 8; i++) begin
            p = hs[i] + ls[i];
            checks += 4;
            if (q_hc[i] !== ((hs[i] > SAT) ? SAT : hs[i])) begin
                failures++; $display("FAIL rand_hc[%0d] got %0d want %0d", i, q_hc[i], hs[i]);
            end
            if (q_pc[i] !== ((p > SAT) ? SAT : p)) begin
                failures++; $display("FAIL rand_pc[%0d] got %0d want %0d", i, q_pc[i], p);
            end
            if (q_ov[i] !== ((p > SAT) ? 1 : 0)) begin
                failures++; $display("FAIL rand_ov[%0d] got %0d want %0d", i, q_ov[i], (p > SAT) ? 1 : 0);
            end
            if (q_cyc[i] !== rise_q[i+1] + LAT) begin
                failures++; $display("FAIL rand_time[%0d] got %0d want %0d", i, q_cyc[i], rise_q[i+1] + LAT);
            end
        end
        exp_hc = hs[7]; exp_pc = hs[7] + ls[7]; exp_ov = 0;
    endtask

    task automatic test_overflow();
        restart();
        drive(1'b1, 150); drive(1'b0, 150);
        drive(1'b1, 50);  drive(1'b0, 50);
        drive(1'b1, 1);
        repeat (LAT + 2) step();
        checks++;
        if (q_hc.size() !== 2) begin failures++; $display("FAIL ovf_count got %0d want 2", q_hc.size()); end
        if (q_hc.size() >= 2) begin
            checks += 6;
            if (q_hc[0] !== 150) begin failures++; $display("FAIL ovf_hc0 got %0d want 150", q_hc[0]); end
            if (q_pc[0] !== SAT) begin failures++; $display("FAIL ovf_pc0 got %0d want %0d", q_pc[0], SAT); end
            if (q_ov[0] !== 1)   begin failures++; $display("FAIL ovf_flag0 got %0d want 1", q_ov[0]); end
            if (q_hc[1] !== 50)  begin failures++; $display("FAIL ovf_hc1 got %0d want 50", q_hc[1]); end
            if (q_pc[1] !== 100) begin failures++; $display("FAIL ovf_pc1 got %0d want 100", q_pc[1]); end
            if (q_ov[1] !== 0)   begin failures++; $display("FAIL ovf_flag1 got %0d want 0", q_ov[1]); end
        end
        exp_hc = 50; exp_pc = 100; exp_ov = 0;
    endtask

    task automatic test_timeout();
        int e;
        int f;
        restart();
        drive(1'b1, 1);
        e = rise_q[0] + LAT;
        wait_neg(e + TIMEOUT - 1);
        checks++;
        if (stuck_high !== 1'b0) begin failures++; $display("FAIL stuck_early got %0b want 0", stuck_high); end
        wait_neg(e + TIMEOUT);
        checks += 6;
        if (stuck_high !== 1'b1) begin failures++; $display("FAIL stuck_high_set got %0b want 1", stuck_high); end
        if (stuck_low !== 1'b0)  begin failures++; $display("FAIL stuck_low_quiet got %0b want 0", stuck_low); end
        if (q_hc.size() !== 0)   begin failures++; $display("FAIL stuck_no_valid got %0d want 0", q_hc.size()); end
        if (high_cnt !== exp_hc)   begin failures++; $display("FAIL stuck_hold_hc got %0d want %0d", high_cnt, exp_hc); end
        if (period_cnt !== exp_pc) begin failures++; $display("FAIL stuck_hold_pc got %0d want %0d", period_cnt, exp_pc); end
        if (overflow !== exp_ov)   begin failures++; $display("FAIL stuck_hold_ov got %0d want %0d", overflow, exp_ov); end
        step();
        f = cyc;
        pwm_in = 1'b0;
        wait_neg(f + LAT - 1);
        checks++;
        if (stuck_high !== 1'b1) begin failures++; $display("FAIL stuck_held got %0b want 1", stuck_high); end
        wait_neg(f + LAT);
        checks++;
        if (stuck_high !== 1'b0) begin failures++; $display("FAIL stuck_clear got %0b want 0", stuck_high); end
        wait_neg(f + LAT + TIMEOUT);
        checks += 2;
        if (stuck_low !== 1'b1)  begin failures++; $display("FAIL stuck_low_set got %0b want 1", stuck_low); end
        if (q_hc.size() !== 0)   begin failures++; $display("FAIL stuck_low_no_valid got %0d want 0", q_hc.size()); end
    endtask

    task automatic test_enable_drop();
        restart();
        drive(1'b1, 20);
        drive(1'b0, 30);
        pwm_in = 1'b1;
        repeat (LAT - 1) step();
        enable = 1'b0;
        repeat (4) step();
        checks += 4;
        if (q_hc.size() !== 0)     begin failures++; $display("FAIL endrop_no_valid got %0d want 0", q_hc.size()); end
        if (high_cnt !== exp_hc)   begin failures++; $display("FAIL endrop_hc got %0d want %0d", high_cnt, exp_hc); end
        if (period_cnt !== exp_pc) begin failures++; $display("FAIL endrop_pc got %0d want %0d", period_cnt, exp_pc); end
        if (overflow !== exp_ov)   begin failures++; $display("FAIL endrop_ov got %0d want %0d", overflow, exp_ov); end
    endtask

    task automatic test_reset_mid();
        restart();
        drive(1'b1, 25); drive(1'b0, 25); drive(1'b1, 10);
        checks++;
        if (q_hc.size() !== 1) begin failures++; $display("FAIL rmid_pre_count got %0d want 1", q_hc.size()); end
        @(negedge clk);
        rst_n = 1'b0;
        pwm_in = 1'b0;
        #1;
        checks += 4;
        if (high_cnt !== 0)   begin failures++; $display("FAIL rmid_hc got %0d want 0", high_cnt); end
        if (period_cnt !== 0) begin failures++; $display("FAIL rmid_pc got %0d want 0", period_cnt); end
        if (overflow !== 0)   begin failures++; $display("FAIL rmid_ov got %0d want 0", overflow); end
        if (meas_valid !== 0) begin failures++; $display("FAIL rmid_valid got %0d want 0", meas_valid); end
        repeat (3) step();
        rst_n = 1'b1;
        clear_log();
        drive(1'b0, 10);
        drive(1'b1, 15); drive(1'b0, 35);
        drive(1'b1, 15); drive(1'b0, 5);
        checks++;
        if (q_hc.size() !== 1) begin failures++; $display("FAIL rmid_count got %0d want 1", q_hc.size()); end
        if (q_hc.size() >= 1) begin
            checks += 3;
            if (q_hc[0] !== 15) begin failures++; $display("FAIL rmid_new_hc got %0d want 15", q_hc[0]); end
            if (q_pc[0] !== 50) begin failures++; $display("FAIL rmid_new_pc got %0d want 50", q_pc[0]); end
            if (q_cyc[0] !== rise_q[1] + LAT) begin
                failures++; $display("FAIL rmid_time got %0d want %0d", q_cyc[0], rise_q[1] + LAT);
            end
        end
    endtask

`ifdef PWM_GLITCH_FILTER_EN
    task automatic test_glitch();
        int starts[$];
        restart();
        repeat (3) begin
            starts.push_back(cyc);
            drive(1'b1, 49); drive(1'b0, 2); drive(1'b1, 49);
            drive(1'b0, 49); drive(1'b1, 2); drive(1'b0, 49);
        end
        starts.push_back(cyc);
        drive(1'b1, 1);
        repeat (LAT + 2) step();
        checks++;
        if (q_hc.size() !== 3) begin failures++; $display("FAIL glitch_count got %0d want 3", q_hc.size()); end
        for (int i = 0; i < q_hc.size() && i < 3; i++) begin
            checks += 3;
            if (q_hc[i] !== 100) begin failures++; $display("FAIL glitch_hc[%0d] got %0d want 100", i, q_hc[i]); end
            if (q_pc[i] !== 200) begin failures++; $display("FAIL glitch_pc[%0d] got %0d want 200", i, q_pc[i]); end
            if (q_cyc[i] !== starts[i+1] + LAT) begin
                failures++; $display("FAIL glitch_time[%0d] got %0d want %0d", i, q_cyc[i], starts[i+1] + LAT);
            end
        end
    endtask
`endif

    initial begin
        pwm_in = 1'b0;
        enable = 1'b0;
        rst_n  = 1'b1;
        #2;
        test_reset();
        test_basic_30_70();
        test_random_periods();
        test_overflow();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
`ifdef PWM_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 Parameter CNT_W, default 17, width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 120000, cycles without a filtered edge before a stuck flag sets.
REQ-003 Parameter FILT_LEN, default 4, consecutive equal samples required by the glitch filter (REQ-024).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pwm_in  input  1  asynchronous PWM waveform to measure, e.g. a breathing-LED drive.
REQ-007 enable  input  1  measurement enable; low forces IDLE.
REQ-008 high_cnt  output  CNT_W  high time of the last complete period, in clk cycles.
REQ-009 period_cnt  output  CNT_W  length of the last complete period, in clk cycles.
REQ-010 meas_valid  output  1  one-cycle pulse when high_cnt/period_cnt update.
REQ-011 stuck_high, stuck_low  output  1 each  no-edge timeout flags.
REQ-012 overflow  output  1  last period exceeded counter range.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer, then edge detection against a registered copy; rise/fall each flag for exactly one cycle.
REQ-014 FSM states SHALL be IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-015 IDLE -> WAIT_RISE when enable=1; any state -> IDLE when enable=0, taking priority over every edge in the same cycle.
REQ-016 WAIT_RISE discards partial periods; on rise -> MEAS_HIGH with high counter=1 and period counter=1.
REQ-017 MEAS_HIGH increments both counters each cycle; on fall -> MEAS_LOW, high counter frozen.
REQ-018 MEAS_LOW increments the period counter; on rise it latches high_cnt and period_cnt, pulses meas_valid for 1 cycle, reloads both counters to 1 and goes to MEAS_HIGH.
REQ-019 For a synchronized waveform high H, low L cycles: high_cnt=H, period_cnt=H+L.
REQ-020 Latency: pwm_in rise to meas_valid is 3 clk cycles with filter out, 3+FILT_LEN with filter in.
REQ-021 Counters SHALL saturate at 2^CNT_W-1, never wrap; a saturated period sets overflow at the next latch, and overflow clears at the next non-saturated latch.
REQ-022 A no-edge run counter reaching TIMEOUT SHALL set stuck_high if the filtered level is 1, else stuck_low, and force WAIT_RISE without meas_valid; both flags clear on the next filtered edge.
REQ-023 high_cnt, period_cnt and overflow SHALL hold their last latched values across IDLE, WAIT_RISE and timeouts.

Configuration
REQ-024 Macro PWM_GLITCH_FILTER_EN defined: the filtered level changes only after FILT_LEN consecutive equal synchronized samples. Undefined: the filtered level equals the synchronizer output, FILT_LEN is ignored, and no filter logic is present.

Reset
REQ-025 rst_n low SHALL asynchronously set state IDLE, clear all counters and synchronizer/filter flops, and drive high_cnt=0, period_cnt=0, meas_valid=0, stuck_high=0, stuck_low=0 and overflow=0.
REQ-026 After rst_n deasserts, the first meas_valid SHALL require two filtered rising edges; a reset mid-period discards that period.

Verification
REQ-027 Filter out, enable=1, pwm_in 30 high/70 low repeated -> meas_valid every 100 cycles, high_cnt=30, period_cnt=100; first pulse at the second rise +3 cycles.
REQ-028 TIMEOUT=1000, pwm_in held 1 after a rise -> stuck_high=1 exactly 1000 cycles after the last edge, no meas_valid; the next fall clears it.
REQ-029 Filter in, FILT_LEN=4, 2-cycle glitches inside a 50/50 period of 200 -> high_cnt=100, period_cnt=200, no extra meas_valid.
REQ-030 CNT_W=8, period 300 cycles -> period_cnt=255, overflow=1; then period 100 -> period_cnt=100, overflow=0.
REQ-031 enable dropped in the same cycle as a rise in MEAS_LOW -> no meas_valid, outputs keep prior values; rst_n pulsed mid-period -> all outputs 0 and the next valid needs two rises.
